// File: rtl/pop_arbiter_rr_if.sv
// Handshake bundle between the egress FIFOs, the pop arbiter and the downstream sink.
// The master modport is the arbiter's view; the slave modport is the FIFO/downstream side.
interface pop_arbiter_rr_if #(
  parameter int unsigned DATA_W = 6
);
  logic              enable;
  logic              empty0;
  logic              empty1;
  logic              empty2;
  logic              empty3;
  logic              empty4;
  logic [DATA_W-1:0] data_in0;
  logic [DATA_W-1:0] data_in1;
  logic [DATA_W-1:0] data_in2;
  logic [DATA_W-1:0] data_in3;
  logic [DATA_W-1:0] data_in4;
  logic              ds_full;
  logic              pop0;
  logic              pop1;
  logic              pop2;
  logic              pop3;
  logic              pop4;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [2:0]        grant_idx;
  logic              idle;

  modport master (
    input  enable, empty0, empty1, empty2, empty3, empty4,
    input  data_in0, data_in1, data_in2, data_in3, data_in4, ds_full,
    output pop0, pop1, pop2, pop3, pop4, data_out, valid_out, grant_idx, idle
  );

  modport slave (
    output enable, empty0, empty1, empty2, empty3, empty4,
    output data_in0, data_in1, data_in2, data_in3, data_in4, ds_full,
    input  pop0, pop1, pop2, pop3, pop4, data_out, valid_out, grant_idx, idle
  );
endinterface

// File: rtl/pop_arbiter_rr.sv
// Round-robin pop arbiter over five egress FIFOs with a fixed two-cycle read datapath.
// Define STRICT_PRIORITY_EN for fixed priority (FIFO 0 highest) instead of round-robin.
module pop_arbiter_rr #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned NUM_Q  = 5
) (
  input  logic             CLK,
  input  logic             reset,
  pop_arbiter_rr_if.master bus
);

  if (NUM_Q != 5) begin : g_num_q_check
    $error("pop_arbiter_rr: NUM_Q must be 5");
  end

  typedef enum logic [1:0] {StIdle, StActive, StStall} state_e;

  state_e            state_q;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [2:0]        grant_idx_q, grant_idx_d;
  logic              inflight_q, inflight_d;
  logic [2:0]        sel_q, sel_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [NUM_Q-1:0]  empty_v;
  logic [NUM_Q-1:0]  grant_v;
  logic [NUM_Q-1:0]  pop_v;
  logic [2:0]        gnt_idx;
  logic [3:0]        cand;
  logic              any_ready;
  logic              pop_any;
  logic              all_empty;
  logic [DATA_W-1:0] rd_word;

  assign empty_v   = {bus.empty4, bus.empty3, bus.empty2, bus.empty1, bus.empty0};
  assign all_empty = &empty_v;

  // Search upward from rr_ptr with wrap. In strict-priority builds rr_ptr stays 0,
  // so the same search degenerates to fixed priority.
  always_comb begin
    any_ready = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_Q; k++) begin
      cand = 4'(rr_ptr_q) + 4'(k);
      if (cand >= 4'(NUM_Q)) begin
        cand = cand - 4'(NUM_Q);
      end
      if (!any_ready && !empty_v[cand[2:0]]) begin
        any_ready = 1'b1;
        gnt_idx   = cand[2:0];
      end
    end
    grant_v = any_ready ? (NUM_Q'(1) << gnt_idx) : '0;
  end

  // ds_full and reset gate the pop combinationally, ahead of any state change.
  assign pop_any = (state_q == StActive) & any_ready & ~bus.ds_full & bus.enable & ~reset;
  assign pop_v   = pop_any ? grant_v : '0;

  assign bus.pop0 = pop_v[0];
  assign bus.pop1 = pop_v[1];
  assign bus.pop2 = pop_v[2];
  assign bus.pop3 = pop_v[3];
  assign bus.pop4 = pop_v[4];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.enable && !all_empty) state_q <= StActive;
        end
        StActive: begin
          if (bus.ds_full)                     state_q <= StStall;
          else if (!bus.enable || all_empty)   state_q <= StIdle;
        end
        StStall: begin
          if (!bus.enable)       state_q <= StIdle;
          else if (!bus.ds_full) state_q <= StActive;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rd_word = bus.data_in0;
    unique case (sel_q)
      3'd0:    rd_word = bus.data_in0;
      3'd1:    rd_word = bus.data_in1;
      3'd2:    rd_word = bus.data_in2;
      3'd3:    rd_word = bus.data_in3;
      3'd4:    rd_word = bus.data_in4;
      default: rd_word = bus.data_in0;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    if (pop_any) begin
      grant_idx_d = gnt_idx;
`ifdef STRICT_PRIORITY_EN
      rr_ptr_d    = '0;
`else
      rr_ptr_d    = (gnt_idx == 3'(NUM_Q - 1)) ? '0 : gnt_idx + 3'd1;
`endif
    end
    // Stage 1 remembers which FIFO was popped; its word appears on data_in a cycle later.
    inflight_d = pop_any;
    sel_d      = pop_any ? gnt_idx : sel_q;
    valid_d    = inflight_q;
    data_d     = inflight_q ? rd_word : data_q;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      inflight_q  <= 1'b0;
      sel_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      inflight_q  <= inflight_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.idle      = (state_q == StIdle) & ~inflight_q & ~valid_q;

endmodule

// File: tb/tb_pop_arbiter_rr.sv
// Directed bench for pop_arbiter_rr: behavioural FIFOs feed the arbiter, expected pops and
// output words are written out cycle by cycle.
module tb_pop_arbiter_rr;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  pop_arbiter_rr_if #(.DATA_W(6)) bus ();

  pop_arbiter_rr #(.DATA_W(6), .NUM_Q(5)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [4:0] emp_b;
  logic [5:0] data_b [5];
  logic [5:0] fq [5][$];
  int         cnt [5];
  int         checks   = 0;
  int         failures = 0;
  string      tname;

  logic [4:0] s_pop;
  logic       s_vo;
  logic       s_idle;
  logic [5:0] s_do;
  logic [2:0] s_gi;

  logic [4:0] p6 [4];
  logic [5:0] d6 [4];

  assign bus.empty0   = emp_b[0];
  assign bus.empty1   = emp_b[1];
  assign bus.empty2   = emp_b[2];
  assign bus.empty3   = emp_b[3];
  assign bus.empty4   = emp_b[4];
  assign bus.data_in0 = data_b[0];
  assign bus.data_in1 = data_b[1];
  assign bus.data_in2 = data_b[2];
  assign bus.data_in3 = data_b[3];
  assign bus.data_in4 = data_b[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic load(input int i, input logic [5:0] w);
    fq[i].push_back(w);
    emp_b[i] = 1'b0;
  endtask

  task automatic flush();
    for (int i = 0; i < 5; i++) begin
      fq[i].delete();
      emp_b[i] = 1'b1;
    end
  endtask

  // Sample the current cycle mid-period, then let the FIFO model react to the pops.
  task automatic tick();
    @(negedge CLK);
    s_pop  = {bus.pop4, bus.pop3, bus.pop2, bus.pop1, bus.pop0};
    s_vo   = bus.valid_out;
    s_do   = bus.data_out;
    s_idle = bus.idle;
    s_gi   = bus.grant_idx;
    chk({tname, ".onehot"}, 32'($countones(s_pop) <= 1), 32'd1);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (s_pop[i]) begin
        chk({tname, ".pop_nonempty"}, 32'(fq[i].size() != 0), 32'd1);
        if (fq[i].size() != 0) data_b[i] = fq[i].pop_front();
        emp_b[i] = (fq[i].size() == 0);
        cnt[i]++;
      end
    end
  endtask

  task automatic step(input logic [4:0] ep, input logic ev, input logic [5:0] ed);
    tick();
    chk({tname, ".pop"}, 32'(s_pop), 32'(ep));
    chk({tname, ".valid"}, 32'(s_vo), 32'(ev));
    if (ev) chk({tname, ".data"}, 32'(s_do), 32'(ed));
  endtask

  initial begin
    reset       = 1'b1;
    bus.enable  = 1'b0;
    bus.ds_full = 1'b0;
    emp_b       = '1;
    for (int i = 0; i < 5; i++) begin
      data_b[i] = '0;
      cnt[i]    = 0;
    end

    tname = "reset";
    step(5'd0, 1'b0, 6'd0);
    chk("reset.idle", 32'(s_idle), 32'd1);
    chk("reset.grant_idx", 32'(s_gi), 32'd0);
    chk("reset.data", 32'(s_do), 32'd0);
    reset = 1'b0;
    step(5'd0, 1'b0, 6'd0);
    chk("reset.idle_after", 32'(s_idle), 32'd1);

`ifndef STRICT_PRIORITY_EN
    // All five FIFOs loaded with two words each.
    tname = "rr5";
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 5; i++) load(i, 6'(16 * j + i + 1));
    bus.enable = 1'b1;
    step(5'd0, 1'b0, 6'd0);
    for (int k = 1; k <= 12; k++) begin
      logic [4:0] ep;
      logic       ev;
      logic [5:0] ed;
      ep = (k <= 10) ? (5'd1 << ((k - 1) % 5)) : 5'd0;
      ev = (k >= 3);
      ed = ev ? 6'(16 * ((k - 3) / 5) + (k - 3) % 5 + 1) : 6'd0;
      step(ep, ev, ed);
    end
    chk("rr5.grant_idx", 32'(s_gi), 32'd4);
    step(5'd0, 1'b0, 6'd0);
    chk("rr5.data_hold", 32'(s_do), 32'd21);
    chk("rr5.idle", 32'(s_idle), 32'd1);

    // Only FIFO 3 has data.
    tname = "single";
    load(3, 6'd3); load(3, 6'd7); load(3, 6'd11); load(3, 6'd15);
    step(5'd0, 1'b0, 6'd0);
    step(5'd8, 1'b0, 6'd0);
    step(5'd8, 1'b0, 6'd0);
    step(5'd8, 1'b1, 6'd3);
    step(5'd8, 1'b1, 6'd7);
    step(5'd0, 1'b1, 6'd11);
    chk("single.grant_idx", 32'(s_gi), 32'd3);
    step(5'd0, 1'b1, 6'd15);
    chk("single.idle_busy", 32'(s_idle), 32'd0);
    step(5'd0, 1'b0, 6'd0);
    chk("single.idle", 32'(s_idle), 32'd1);

    // Downstream almost-full after the third pop; rr_ptr starts at 4.
    tname = "stall";
    for (int i = 0; i < 5; i++) load(i, 6'(40 + i));
    step(5'd0, 1'b0, 6'd0);
    step(5'd16, 1'b0, 6'd0);
    step(5'd1, 1'b0, 6'd0);
    step(5'd2, 1'b1, 6'd44);
    bus.ds_full = 1'b1;
    step(5'd0, 1'b1, 6'd40);
    step(5'd0, 1'b1, 6'd41);
    step(5'd0, 1'b0, 6'd0);
    chk("stall.idle", 32'(s_idle), 32'd0);
    bus.ds_full = 1'b0;
    step(5'd0, 1'b0, 6'd0);
    step(5'd4, 1'b0, 6'd0);
    step(5'd8, 1'b0, 6'd0);
    step(5'd0, 1'b1, 6'd42);
    step(5'd0, 1'b1, 6'd43);
    chk("stall.grant_idx", 32'(s_gi), 32'd3);
    step(5'd0, 1'b0, 6'd0);
    chk("stall.idle_end", 32'(s_idle), 32'd1);

    // enable drops mid-burst with FIFOs 1 and 4 loaded; rr_ptr starts at 4.
    tname = "enable_drop";
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    load(1, 6'd50); load(1, 6'd51); load(1, 6'd52);
    load(4, 6'd60); load(4, 6'd61); load(4, 6'd62);
    step(5'd0, 1'b0, 6'd0);
    step(5'd16, 1'b0, 6'd0);
    step(5'd2, 1'b0, 6'd0);
    step(5'd16, 1'b1, 6'd60);
    bus.enable = 1'b0;
    step(5'd0, 1'b1, 6'd50);
    step(5'd0, 1'b1, 6'd61);
    chk("enable_drop.idle_busy", 32'(s_idle), 32'd0);
    step(5'd0, 1'b0, 6'd0);
    chk("enable_drop.idle", 32'(s_idle), 32'd1);
    step(5'd0, 1'b0, 6'd0);
    chk("enable_drop.cnt1", 32'(cnt[1]), 32'd1);
    chk("enable_drop.cnt4", 32'(cnt[4]), 32'd2);

    // Asynchronous reset in the middle of a burst over FIFOs 0 and 2; rr_ptr starts at 0.
    tname = "reset_mid";
    flush();
    for (int w = 0; w < 4; w++) begin
      load(0, 6'(70 + w));
      load(2, 6'(80 + w));
    end
    bus.enable = 1'b1;
    step(5'd0, 1'b0, 6'd0);
    step(5'd1, 1'b0, 6'd0);
    step(5'd4, 1'b0, 6'd0);
    step(5'd1, 1'b1, 6'd70);
    reset = 1'b1;
    #1;
    chk("reset_mid.pops",
        32'({bus.pop4, bus.pop3, bus.pop2, bus.pop1, bus.pop0}), 32'd0);
    chk("reset_mid.valid", 32'(bus.valid_out), 32'd0);
    chk("reset_mid.data", 32'(bus.data_out), 32'd0);
    chk("reset_mid.idle", 32'(bus.idle), 32'd1);
    chk("reset_mid.grant_idx", 32'(bus.grant_idx), 32'd0);
    step(5'd0, 1'b0, 6'd0);
    reset = 1'b0;
    step(5'd0, 1'b0, 6'd0);
    step(5'd1, 1'b0, 6'd0);
    step(5'd4, 1'b0, 6'd0);
    step(5'd1, 1'b1, 6'd72);
    bus.enable = 1'b0;
    step(5'd0, 1'b1, 6'd81);
    step(5'd0, 1'b1, 6'd73);
    step(5'd0, 1'b0, 6'd0);
    chk("reset_mid.idle_end", 32'(s_idle), 32'd1);
`endif

    // FIFOs 0 and 4 with two words each, starting from a fresh pointer.
    tname = "prio";
    flush();
    reset = 1'b1;
    step(5'd0, 1'b0, 6'd0);
    reset = 1'b0;
    load(0, 6'd90); load(0, 6'd91);
    load(4, 6'd94); load(4, 6'd95);
    bus.enable = 1'b1;
`ifdef STRICT_PRIORITY_EN
    p6 = '{5'd1, 5'd1, 5'd16, 5'd16};
    d6 = '{6'd90, 6'd91, 6'd94, 6'd95};
`else
    p6 = '{5'd1, 5'd16, 5'd1, 5'd16};
    d6 = '{6'd90, 6'd94, 6'd91, 6'd95};
`endif
    step(5'd0, 1'b0, 6'd0);
    for (int k = 1; k <= 6; k++) begin
      step((k <= 4) ? p6[k - 1] : 5'd0, (k >= 3), (k >= 3) ? d6[k - 3] : 6'd0);
    end
    chk("prio.grant_idx", 32'(s_gi), 32'd4);
    step(5'd0, 1'b0, 6'd0);
    chk("prio.idle", 32'(s_idle), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
